seg_pipe_adder: RTL and testbench

- Parametrised, fully pipelined N-bit adder/subtractor. Carry ripples one SEG-bit segment per clock stage, so fmax is set by a SEG-bit add regardless of N.
- Valid/ready handshake with backpressure on both sides.
- Sits in the datapath library as the general replacement for the fixed-width, segment-chained 32-bit adder. It adds subtract mode, signed-overflow flag, stall handling and reset.

---
 rtl/seg_pipe_adder_if.sv | 29 ++
 rtl/seg_pipe_adder.sv | 97 +++++++++
 tb/tb_seg_pipe_adder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_pipe_adder_if.sv
// seg_pipe_adder_if: operand and result handshake bundle for seg_pipe_adder.
// Holds in_valid/in_ready with a, b, cin, sub on the input side and
// out_valid/out_ready with s, cout, ovf on the output side.
// Ports: none (signal bundle only); master = producer/consumer side, slave = adder side.
interface seg_pipe_adder_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: pipelined N-bit adder/subtractor, carry resolved SEG bits per stage.
// Latency: STAGES = N/SEG cycles from accept to out_valid when not stalled.
// Backpressure: whole pipe freezes while a result waits; in_ready = !out_valid | out_ready.
// Ports: clk, rst (async, active-high); bus (slave modport): in_valid/in_ready, a, b,
//        cin, sub in; out_valid/out_ready, s, cout, ovf out.
module seg_pipe_adder #(
  parameter int N   = 32,
  parameter int SEG = 8
) (
  input  logic            clk,
  input  logic            rst,
  seg_pipe_adder_if.slave bus
);
  localparam int STAGES = (SEG > 0) ? (N / SEG) : 1;

  if (SEG < 1 || N < SEG || (N % SEG) != 0) begin : g_bad_params
    $error("seg_pipe_adder: N (%0d) must be a positive multiple of SEG (%0d)", N, SEG);
  end

  // Per-stage state. a/b hold the operand segments not yet added, shifted so the
  // next segment to resolve sits in the low SEG bits. r collects resolved result
  // segments from the top down, so after the last stage segment 0 lands at the LSBs.
  typedef struct packed {
    logic         vld;
    logic         carry;
    logic         sign_a;
    logic         sign_b;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] r;
  } stage_t;

  stage_t       st_q  [STAGES];
  stage_t       st_d  [STAGES];
  stage_t       st_in [STAGES];
  logic         advance;
  logic [N-1:0] b_eff;
  logic         c_in0;
  logic [SEG:0] seg_sum;

  // Subtract is a + ~b + 1, so the forced carry-in replaces cin.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_in0 = bus.sub ? 1'b1 : bus.cin;

  assign st_in[0] = '{
    vld:    bus.in_valid,
    carry:  c_in0,
    sign_a: bus.a[N-1],
    sign_b: b_eff[N-1],
    a:      bus.a,
    b:      b_eff,
    r:      '0
  };

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign st_in[k] = st_q[k-1];
  end

  always_comb begin
    advance = !st_q[STAGES-1].vld || bus.out_ready;
    seg_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = st_q[k];
      seg_sum = {1'b0, st_in[k].a[SEG-1:0]} + {1'b0, st_in[k].b[SEG-1:0]}
              + {{SEG{1'b0}}, st_in[k].carry};
      if (advance) begin
        st_d[k].vld = st_in[k].vld;
        // Bubbles leave the data untouched so outputs keep their last value.
        if (st_in[k].vld) begin
          st_d[k].carry  = seg_sum[SEG];
          st_d[k].sign_a = st_in[k].sign_a;
          st_d[k].sign_b = st_in[k].sign_b;
          st_d[k].a      = st_in[k].a >> SEG;
          st_d[k].b      = st_in[k].b >> SEG;
          st_d[k].r      = (st_in[k].r >> SEG) | (N'(seg_sum[SEG-1:0]) << (N - SEG));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      st_q <= st_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = st_q[STAGES-1].vld;
  assign bus.s         = st_q[STAGES-1].r;
  assign bus.cout      = st_q[STAGES-1].carry;
  assign bus.ovf       = (st_q[STAGES-1].sign_a == st_q[STAGES-1].sign_b) &&
                         (st_q[STAGES-1].r[N-1] != st_q[STAGES-1].sign_a);
endmodule

// File: tb/tb_seg_pipe_adder.sv
module tb_seg_pipe_adder;
  localparam int NI = 4;

  function automatic int cfg_n(input int i);
    case (i)
      0: return 32;
      1: return 16;
      2: return 64;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      0: return 8;
      1: return 4;
      2: return 16;
      default: return 8;
    endcase
  endfunction

  logic        clk;
  logic        rst;
  logic        drv_valid;
  logic        drv_ready;
  logic [63:0] drv_a;
  logic [63:0] drv_b;
  logic        drv_cin;
  logic        drv_sub;

  logic        mon_valid [NI];
  logic        mon_ready [NI];
  logic [63:0] mon_s     [NI];
  logic        mon_cout  [NI];
  logic        mon_ovf   [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int WN = cfg_n(gi);
    localparam int WS = cfg_s(gi);
    seg_pipe_adder_if #(.N(WN)) sif ();
    seg_pipe_adder #(.N(WN), .SEG(WS)) u_dut (.clk(clk), .rst(rst), .bus(sif));
    assign sif.in_valid  = drv_valid;
    assign sif.a         = drv_a[WN-1:0];
    assign sif.b         = drv_b[WN-1:0];
    assign sif.cin       = drv_cin;
    assign sif.sub       = drv_sub;
    assign sif.out_ready = drv_ready;
    assign mon_valid[gi] = sif.out_valid;
    assign mon_ready[gi] = sif.in_ready;
    assign mon_s[gi]     = 64'(sif.s);
    assign mon_cout[gi]  = sif.cout;
    assign mon_ovf[gi]   = sif.ovf;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    int          t;
  } rec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  int          checks;
  int          errors;
  int          cnt;
  bit          lat_chk;
  rec_t        ring   [NI][64];
  int          head   [NI];
  int          tail   [NI];
  bit          hold_p [NI];
  logic [63:0] hold_s [NI];
  logic        hold_c [NI];
  logic        hold_o [NI];
  vec_t        vecs   [10];

  task automatic chk(input string name, input int inst, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h", name, inst, got, want);
    end
  endtask

  // Scoreboard for all instances, run once per negedge.
  task automatic sb_step();
    logic [63:0] mask, am, bm;
    logic [64:0] full;
    rec_t        r;
    int          n;
    cnt++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        head[i]   = 0;
        tail[i]   = 0;
        hold_p[i] = 1'b0;
      end else begin
        if (hold_p[i]) begin
          chk("hold_valid", i, 64'(mon_valid[i]), 64'd1);
          chk("hold_s", i, mon_s[i], hold_s[i]);
          chk("hold_cout", i, 64'(mon_cout[i]), 64'(hold_c[i]));
          chk("hold_ovf", i, 64'(mon_ovf[i]), 64'(hold_o[i]));
        end
        chk("in_ready_rule", i, 64'(mon_ready[i]), 64'(!mon_valid[i] || drv_ready));
        if (mon_valid[i] && drv_ready) begin
          chk("beat_expected", i, 64'(tail[i] > head[i]), 64'd1);
          if (tail[i] > head[i]) begin
            r = ring[i][head[i] % 64];
            head[i]++;
            chk("s", i, mon_s[i], r.s);
            chk("cout", i, 64'(mon_cout[i]), 64'(r.cout));
            chk("ovf", i, 64'(mon_ovf[i]), 64'(r.ovf));
            if (lat_chk) chk("latency", i, 64'(cnt - r.t), 64'(cfg_n(i) / cfg_s(i)));
          end
        end
        hold_p[i] = mon_valid[i] && !drv_ready;
        hold_s[i] = mon_s[i];
        hold_c[i] = mon_cout[i];
        hold_o[i] = mon_ovf[i];
        if (drv_valid && mon_ready[i]) begin
          n    = cfg_n(i);
          mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
          am   = drv_a & mask;
          bm   = drv_b & mask;
          if (drv_sub) begin
            full   = {1'b0, am} - {1'b0, bm};
            r.cout = (am >= bm);
            r.ovf  = (am[n-1] != bm[n-1]) && (full[n-1] != am[n-1]);
          end else begin
            full   = {1'b0, am} + {1'b0, bm} + 65'(drv_cin);
            r.cout = full[n];
            r.ovf  = (am[n-1] == bm[n-1]) && (full[n-1] != am[n-1]);
          end
          r.s = full[63:0] & mask;
          r.t = cnt;
          ring[i][tail[i] % 64] = r;
          tail[i]++;
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    sb_step();
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat on the 32/8 instance; checks latency and result directly.
  task automatic run_one(input string name, input vec_t v);
    int t0;
    bit seen;
    drv_valid = 1'b1;
    drv_a     = {32'h0, v.a};
    drv_b     = {32'h0, v.b};
    drv_cin   = v.cin;
    drv_sub   = v.sub;
    sample();
    t0 = cnt;
    edge_step();
    drv_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      sample();
      if (mon_valid[0]) seen = 1'b1;
      else edge_step();
    end
    chk({name, "_latency"}, 0, 64'(cnt - t0), 64'd4);
    chk({name, "_s"}, 0, mon_s[0], {32'h0, v.s});
    chk({name, "_cout"}, 0, 64'(mon_cout[0]), 64'(v.cout));
    chk({name, "_ovf"}, 0, 64'(mon_ovf[0]), 64'(v.ovf));
    edge_step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    checks = 0;
    errors = 0;
    cnt    = 0;
    lat_chk = 1'b1;
    for (int i = 0; i < NI; i++) begin
      head[i] = 0; tail[i] = 0; hold_p[i] = 1'b0;
      hold_s[i] = '0; hold_c[i] = 1'b0; hold_o[i] = 1'b0;
    end
    //          a             b             cin   sub   s             cout  ovf
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h9999999A, 1'b0, 1'b0};
    vecs[5] = '{32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0};
    vecs[6] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[8] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[9] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b1;
    drv_valid = 1'b0; drv_ready = 1'b1;
    drv_a = '0; drv_b = '0; drv_cin = 1'b0; drv_sub = 1'b0;

    // Reset state
    sample();
    chk("rst_out_valid", 0, 64'(mon_valid[0]), 64'd0);
    chk("rst_s", 0, mon_s[0], 64'd0);
    chk("rst_cout", 0, 64'(mon_cout[0]), 64'd0);
    chk("rst_ovf", 0, 64'(mon_ovf[0]), 64'd0);
    for (int i = 1; i < NI; i++) chk("rst_out_valid", i, 64'(mon_valid[i]), 64'd0);
    edge_step();
    rst = 1'b0;

    // Directed vectors
    for (int v = 0; v < 10; v++) run_one($sformatf("vec%0d", v), vecs[v]);

    // Back-to-back streaming, no stalls
    for (int i = 0; i < 100; i++) begin
      drv_valid = 1'b1;
      drv_a     = {$urandom, $urandom};
      drv_b     = {$urandom, $urandom};
      drv_cin   = 1'($urandom_range(0, 1));
      drv_sub   = ($urandom_range(0, 3) == 0);
      sample();
      chk("stream_in_ready", 0, 64'(mon_ready[0]), 64'd1);
      if (i >= 4) chk("stream_out_valid", 0, 64'(mon_valid[0]), 64'd1);
      edge_step();
    end
    drv_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin sample(); edge_step(); end

    // Random backpressure with continuous input
    lat_chk = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drv_valid = 1'b1;
      drv_ready = 1'($urandom_range(0, 1));
      drv_a     = {$urandom, $urandom};
      drv_b     = {$urandom, $urandom};
      drv_cin   = 1'($urandom_range(0, 1));
      drv_sub   = 1'($urandom_range(0, 1));
      sample();
      edge_step();
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin sample(); edge_step(); end
    for (int i = 0; i < NI; i++) chk("drained_pending", i, 64'(tail[i] - head[i]), 64'd0);
    lat_chk = 1'b1;

    // Reset in the middle of three in-flight beats
    for (int i = 0; i < 3; i++) begin
      drv_valid = 1'b1;
      drv_a     = {$urandom, $urandom} | 64'h8000_8000_8000_8080;
      drv_b     = {$urandom, $urandom};
      drv_cin   = 1'b1;
      drv_sub   = 1'b0;
      sample();
      edge_step();
    end
    drv_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) chk("midrst_out_valid", i, 64'(mon_valid[i]), 64'd0);
    chk("midrst_s", 0, mon_s[0], 64'd0);
    chk("midrst_cout", 0, 64'(mon_cout[0]), 64'd0);
    chk("midrst_ovf", 0, 64'(mon_ovf[0]), 64'd0);
    sample();
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      for (int i = 0; i < NI; i++) chk("post_rst_quiet", i, 64'(mon_valid[i]), 64'd0);
      edge_step();
    end
    run_one("fresh", '{32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++) begin sample(); edge_step(); end
    for (int i = 0; i < NI; i++) chk("final_pending", i, 64'(tail[i] - head[i]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
